rocket_launch_manager: RTL and testbench

// - Initiator side of the rocket activation interface: owns a pool of NUM_ROCKETS single-rocket controllers.
// - On a fire request, picks a free slot, presents launch X/Y/speed, then raises that slot's isActive.
// - Retires slots on border-reach or hit, and enforces a frame-based cooldown between launches.
// - Sits between player input/ship position logic and the per-rocket motion controllers.

---
 rtl/space_invaders_pkg.sv | 6 +
 rtl/rocket_slot_allocator.sv | 15 +
 rtl/rocket_launch_manager.sv | 97 +++++++++
 tb/tb_rocket_launch_manager.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/space_invaders_pkg.sv
// space_invaders_pkg: shared screen-coordinate and rocket-speed types
package space_invaders_pkg;
  typedef logic signed [10:0] coord_t;
  typedef logic signed [8:0] speed_t;
  localparam int FIXED_POINT_MULTIPLIER = 64;
endpackage

// File: rtl/rocket_slot_allocator.sv
// rocket_slot_allocator: picks the lowest-index free rocket slot and flags whether any is free
module rocket_slot_allocator #(
  parameter int N = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  active,
  output logic [SW-1:0] slot,
  output logic          any_free
);
  always_comb begin
    slot = '0;
    for (int i = N - 1; i >= 0; i--) slot = !active[i] ? SW'(i) : slot;
  end
  assign any_free = ~&active;
endmodule

// File: rtl/rocket_launch_manager.sv
// rocket_launch_manager: fire-request FSM, rocket slot pool and frame-based launch cooldown.
// Build option AUTO_FIRE_EN: fire on button level (repeats each cooldown) instead of rising edge.
module rocket_launch_manager
  import space_invaders_pkg::*;
#(
  parameter int NUM_ROCKETS     = 4,
  parameter int ROCKET_SPEED    = -256,
  parameter int X_OFFSET        = 14,
  parameter int Y_OFFSET        = -12,
  parameter int COOLDOWN_FRAMES = 8,
  localparam int SW = (NUM_ROCKETS > 1) ? $clog2(NUM_ROCKETS) : 1,
  localparam int CW = $clog2(NUM_ROCKETS + 1),
  localparam int DW = $clog2(COOLDOWN_FRAMES + 1)
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   fireButton,
  input  coord_t                 shipX,
  input  coord_t                 shipY,
  input  logic [NUM_ROCKETS-1:0] reachedBorder,
  input  logic [NUM_ROCKETS-1:0] rocketHit,
  output logic [NUM_ROCKETS-1:0] isActive,
  output coord_t                 initialX,
  output coord_t                 initialY,
  output speed_t                 initialSpeed,
  output logic                   fireAccepted,
  output logic [CW-1:0]          rocketsInFlight
);
  typedef enum logic [1:0] {IDLE, ARM, LAUNCH, COOLDOWN} state_t;
  state_t state, state_nx;
  logic [SW-1:0] free_slot, launch_slot;
  logic any_free, fire_trig;
  logic [NUM_ROCKETS-1:0] mask, retire, launch_bit, active_nx;
  logic [DW-1:0] cooldown;
  logic [CW-1:0] count_nx;
  rocket_slot_allocator #(.N(NUM_ROCKETS)) u_alloc (
    .active(isActive),
    .slot(free_slot),
    .any_free(any_free)
  );
`ifdef AUTO_FIRE_EN
  assign fire_trig = fireButton;
`else
  logic fire_prev;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) fire_prev <= 1'b0;
    else fire_prev <= fireButton;
  assign fire_trig = fireButton & ~fire_prev;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = (fire_trig && cooldown == '0 && any_free) ? ARM : IDLE;
      ARM:      state_nx = LAUNCH;
      LAUNCH:   state_nx = COOLDOWN;
      COOLDOWN: state_nx = (cooldown == '0) ? IDLE : COOLDOWN;
      default:  state_nx = IDLE;
    endcase
  end
  // A freshly launched slot ignores reachedBorder for one clk: its controller position is still stale
  always_comb begin
    launch_bit = (state == LAUNCH) ? NUM_ROCKETS'(1) << launch_slot : '0;
    retire = isActive & (rocketHit | (reachedBorder & ~mask));
    active_nx = (isActive & ~retire) | launch_bit;
    count_nx = '0;
    for (int i = 0; i < NUM_ROCKETS; i++) count_nx = count_nx + CW'(active_nx[i]);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      isActive        <= '0;
      mask            <= '0;
      launch_slot     <= '0;
      initialX        <= '0;
      initialY        <= '0;
      initialSpeed    <= '0;
      fireAccepted    <= 1'b0;
      rocketsInFlight <= '0;
      cooldown        <= '0;
    end else begin
      isActive        <= active_nx;
      mask            <= launch_bit;
      fireAccepted    <= state == LAUNCH;
      rocketsInFlight <= count_nx;
      cooldown        <= (state == LAUNCH) ? DW'(COOLDOWN_FRAMES) :
                         (state == COOLDOWN && startOfFrame && cooldown != '0) ? cooldown - DW'(1) : cooldown;
      if (state == ARM) begin
        launch_slot  <= free_slot;
        initialX     <= shipX + coord_t'(X_OFFSET);
        initialY     <= shipY + coord_t'(Y_OFFSET);
        initialSpeed <= speed_t'(ROCKET_SPEED);
      end
    end
endmodule

// File: tb/tb_rocket_launch_manager.sv
// tb_rocket_launch_manager: directed vector table plus hand-written launch/cooldown/mask/reset sequences
module tb_rocket_launch_manager;
  import space_invaders_pkg::*;
  logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0, fireButton = 1'b0;
  coord_t shipX = '0, shipY = '0;
  logic [3:0] reachedBorder = '0, rocketHit = '0, isActive;
  coord_t initialX, initialY;
  speed_t initialSpeed;
  logic fireAccepted;
  logic [2:0] rocketsInFlight;
  int errors = 0, checks = 0, fa_cnt = 0, fa0;
  always #5 clk = ~clk;
  rocket_launch_manager dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireButton(fireButton),
    .shipX(shipX), .shipY(shipY), .reachedBorder(reachedBorder), .rocketHit(rocketHit),
    .isActive(isActive), .initialX(initialX), .initialY(initialY), .initialSpeed(initialSpeed),
    .fireAccepted(fireAccepted), .rocketsInFlight(rocketsInFlight)
  );
  typedef struct {
    int sx, sy;
    logic [3:0] hit;
    int ex, ey;
    logic [3:0] act;
    logic fa;
    int rif;
  } vec_t;
  vec_t tbl[5];
  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (fireAccepted === 1'b1) fa_cnt++;
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      tick();
    end
  endtask
  // returns at the negedge after the ARM edge, i.e. when launch coordinates are visible
  task automatic press(input int sx, input int sy);
    shipX = coord_t'(sx);
    shipY = coord_t'(sy);
    fireButton = 1'b1;
    tick();
    fireButton = 1'b0;
    tick();
  endtask
  initial begin
    tbl[0] = '{sx: 1015, sy: -1020, hit: 4'b0000, ex: -1019, ey: 1016, act: 4'b0111, fa: 1'b1, rif: 3};
    tbl[1] = '{sx: -14, sy: 12, hit: 4'b0000, ex: 0, ey: 0, act: 4'b1111, fa: 1'b1, rif: 4};
    tbl[2] = '{sx: 5, sy: 5, hit: 4'b0000, ex: 0, ey: 0, act: 4'b1111, fa: 1'b0, rif: 4};
    tbl[3] = '{sx: 200, sy: -300, hit: 4'b0100, ex: 214, ey: -312, act: 4'b1111, fa: 1'b1, rif: 4};
    tbl[4] = '{sx: -1024, sy: -1024, hit: 4'b1011, ex: -1010, ey: 1012, act: 4'b0101, fa: 1'b1, rif: 2};
    tick();
    tick();
    chk("reset_active", isActive, 0);
    chk("reset_x", initialX, 0);
    chk("reset_y", initialY, 0);
    chk("reset_speed", initialSpeed, 0);
    chk("reset_fa", fireAccepted, 0);
    chk("reset_rif", rocketsInFlight, 0);
    resetN = 1'b1;
    tick();
    press(100, 400);
    chk("first_x", initialX, 114);
    chk("first_y", initialY, 388);
    chk("first_speed", initialSpeed, -256);
    chk("first_active_pre", isActive, 0);
    tick();
    chk("first_active", isActive, 4'b0001);
    chk("first_fa", fireAccepted, 1);
    chk("first_rif", rocketsInFlight, 1);
    tick();
    chk("first_fa_drop", fireAccepted, 0);
    frames(3);
    press(300, 300);
    chk("cooldown_x_hold", initialX, 114);
    tick();
    chk("cooldown_active", isActive, 4'b0001);
    chk("cooldown_fa", fireAccepted, 0);
    frames(5);
    press(0, 0);
    chk("second_x", initialX, 14);
    chk("second_y", initialY, -12);
    tick();
    chk("second_active", isActive, 4'b0011);
    for (int k = 0; k < 5; k++) begin
      frames(8);
      if (tbl[k].hit != '0) begin
        rocketHit = tbl[k].hit;
        tick();
        rocketHit = '0;
      end
      press(tbl[k].sx, tbl[k].sy);
      chk($sformatf("vec%0d_x", k), initialX, tbl[k].ex);
      chk($sformatf("vec%0d_y", k), initialY, tbl[k].ey);
      chk($sformatf("vec%0d_speed", k), initialSpeed, -256);
      tick();
      chk($sformatf("vec%0d_active", k), isActive, tbl[k].act);
      chk($sformatf("vec%0d_fa", k), fireAccepted, tbl[k].fa);
      chk($sformatf("vec%0d_rif", k), rocketsInFlight, tbl[k].rif);
    end
    rocketHit = 4'b1111;
    tick();
    rocketHit = '0;
    frames(8);
    reachedBorder = 4'b0001;
    press(10, 10);
    tick();
    chk("mask_launch", isActive, 4'b0001);
    tick();
    chk("mask_hold", isActive, 4'b0001);
    tick();
    chk("mask_retire", isActive, 4'b0000);
    chk("mask_rif", rocketsInFlight, 0);
    reachedBorder = '0;
    for (int k = 0; k < 3; k++) begin
      frames(8);
      press(0, 0);
      tick();
    end
    chk("three_busy", isActive, 4'b0111);
    frames(8);
    fireButton = 1'b1;
    tick();
    fireButton = 1'b0;
    rocketHit = 4'b0001;
    tick();
    rocketHit = '0;
    tick();
    chk("arm_retire_active", isActive, 4'b1110);
    chk("arm_retire_rif", rocketsInFlight, 3);
    frames(8);
    press(0, 0);
    tick();
    chk("all_busy", isActive, 4'b1111);
    frames(8);
    fa0 = fa_cnt;
    fireButton = 1'b1;
    reachedBorder = 4'b1000;
    tick();
    fireButton = 1'b0;
    reachedBorder = '0;
    repeat (4) tick();
    chk("full_fire_ignored", fa_cnt, fa0);
    chk("full_retire", isActive, 4'b0111);
    press(0, 0);
    tick();
    chk("freed_slot3", isActive, 4'b1111);
    rocketHit = 4'b1111;
    tick();
    rocketHit = '0;
    frames(8);
    fa_cnt = 0;
    fireButton = 1'b1;
    frames(40);
    fireButton = 1'b0;
    tick();
`ifdef AUTO_FIRE_EN
    chk("hold_launches", fa_cnt, 4);
    chk("hold_active", isActive, 4'b1111);
`else
    chk("hold_launches", fa_cnt, 1);
    chk("hold_active", isActive, 4'b0001);
`endif
    rocketHit = 4'b1111;
    tick();
    rocketHit = '0;
    frames(8);
    press(50, 50);
    chk("pre_reset_x", initialX, 64);
    resetN = 1'b0;
    #1;
    chk("midreset_active", isActive, 0);
    chk("midreset_fa", fireAccepted, 0);
    chk("midreset_rif", rocketsInFlight, 0);
    chk("midreset_x", initialX, 0);
    tick();
    chk("midreset_no_partial", isActive, 0);
    resetN = 1'b1;
    tick();
    tick();
    chk("post_reset_idle", isActive, 0);
    press(100, 400);
    tick();
    chk("post_reset_launch", isActive, 4'b0001);
    chk("post_reset_x", initialX, 114);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
